// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID pipeline buffer: head register feeds decode, skid register absorbs back-pressure.
// Optional IF_ID_STALL_CNT_EN adds a saturating stall_cycles counter of fetches refused while full.
module if_id_buffer #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
`ifdef IF_ID_STALL_CNT_EN
    output logic [15:0]        stall_cycles,
`endif
    output logic [1:0]         count
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]         r_count;
    logic [ADDR_W-1:0]  r_head_pc;
    logic [INSTR_W-1:0] r_head_instr;
    logic [ADDR_W-1:0]  r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;

    logic [1:0] w_count_next;
    logic       w_push;
    logic       w_pop;
    logic       w_load_head_in;
    logic       w_load_head_skid;
    logic       w_load_skid;

    // State and data registers; data loads are already suppressed on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= S_EMPTY;
            r_head_pc    <= '0;
            r_head_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_load_head_in) begin
                r_head_pc    <= in_pc;
                r_head_instr <= in_instr;
            end else if (w_load_head_skid) begin
                r_head_pc    <= r_skid_pc;
                r_head_instr <= r_skid_instr;
            end
            if (w_load_skid) begin
                r_skid_pc    <= in_pc;
                r_skid_instr <= in_instr;
            end
        end
    end

    // Next-state and data-steering decode.
    always_comb begin
        w_count_next     = r_count;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_count_next = S_EMPTY;
        end else begin
            case (r_count)
                S_EMPTY: begin
                    if (w_push) begin
                        w_count_next   = S_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_head_in = 1'b1;
                    end else if (w_push) begin
                        w_count_next = S_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_count_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_count_next     = S_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_count_next = S_EMPTY;
            endcase
        end
    end

    // Handshakes depend only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready  = (r_count != S_FULL);
        out_valid = (r_count != S_EMPTY);
        w_push    = in_valid & in_ready;
        w_pop     = out_valid & out_ready;
        out_pc    = r_head_pc;
        out_instr = r_head_instr;
        count     = r_count;
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (in_valid && !in_ready && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based reference model.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  count;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    logic [63:0] model_q[$];
    int          model_stall = 0;

    if_id_buffer #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
`ifdef IF_ID_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded FIFO of {pc, instr}, capacity two.
    always @(posedge clk) begin
        int sz;
        bit do_push;
        bit do_pop;
        sz = model_q.size();
        if (rst) begin
            model_q.delete();
            model_stall = 0;
        end else begin
            if (in_valid && sz == 2 && model_stall < 65535) model_stall++;
            if (flush) begin
                model_q.delete();
            end else begin
                do_push = in_valid && (sz < 2);
                do_pop  = out_ready && (sz > 0);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) model_q.push_back({in_pc, in_instr});
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count", 64'(count), 64'(model_q.size()));
            chk("m_in_ready", 64'(in_ready), 64'(model_q.size() != 2));
            chk("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            if (model_q.size() != 0)
                chk("m_head", {out_pc, out_instr}, model_q[0]);
`ifdef IF_ID_STALL_CNT_EN
            chk("m_stall", 64'(stall_cycles), 64'(model_stall));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_en = 1;
        // Reset then idle
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);

        // Streaming
        drive(1, 32'd1, 32'h0000_1111, 1, 0);
        tick();
        chk("str_pc1", 64'(out_pc), 64'd1);
        chk("str_instr1", 64'(out_instr), 64'h1111);
        chk("str_count1", 64'(count), 64'd1);
        drive(1, 32'd2, 32'h0000_2222, 1, 0);
        tick();
        chk("str_pc2", 64'(out_pc), 64'd2);
        chk("str_count2", 64'(count), 64'd1);
        chk("str_in_ready", 64'(in_ready), 64'd1);
        drive(0, 0, 0, 1, 0);
        tick();
        chk("str_drain", 64'(count), 64'd0);

        // Back-pressure
        drive(1, 32'd5, 32'h5555, 0, 0);
        tick();
        chk("bp_pc5", 64'(out_pc), 64'd5);
        drive(1, 32'd6, 32'h6666, 0, 0);
        tick();
        chk("bp_full", 64'(count), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'd7, 32'h7777, 0, 0);
        tick();
        chk("bp_hold_pc", 64'(out_pc), 64'd5);
        chk("bp_hold_count", 64'(count), 64'd2);
        drive(1, 32'd7, 32'h7777, 1, 0);
        tick();
        chk("bp_pop_pc6", 64'(out_pc), 64'd6);
        chk("bp_pop_count", 64'(count), 64'd1);
        tick();
        chk("bp_pc7", 64'(out_pc), 64'd7);
        chk("bp_pc7_instr", 64'(out_instr), 64'h7777);
        drive(0, 0, 0, 1, 0);
        tick();
        chk("bp_drain", 64'(count), 64'd0);

        // Flush while full, then flush dropping a same-cycle push
        drive(1, 32'd8, 32'h8888, 0, 0);
        tick();
        drive(1, 32'd9, 32'h9999, 0, 0);
        tick();
        chk("fl_full", 64'(count), 64'd2);
        drive(1, 32'd10, 32'hAAAA, 0, 1);
        tick();
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        drive(1, 32'd11, 32'hBBBB, 0, 0);
        tick();
        drive(1, 32'd12, 32'hCCCC, 1, 1);
        tick();
        chk("fl_push_drop", 64'(count), 64'd0);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("fl_stay_empty", 64'(out_valid), 64'd0);

        // Synchronous reset mid-stream
        drive(1, 32'd13, 32'hD0D0, 0, 0);
        tick();
        drive(1, 32'd14, 32'hE0E0, 0, 0);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_out_pc", 64'(out_pc), 64'd0);
        chk("mr_out_instr", 64'(out_instr), 64'd0);
        drive(1, 32'd20, 32'h2020, 0, 0);
        tick();
        chk("mr_pc20", 64'(out_pc), 64'd20);
        chk("mr_count1", 64'(count), 64'd1);
        drive(0, 0, 0, 1, 0);
        tick();
        chk("mr_drain", 64'(count), 64'd0);

`ifdef IF_ID_STALL_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 32'd30, 32'h3030, 0, 0);
        tick();
        drive(1, 32'd31, 32'h3131, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("st_five", 64'(stall_cycles), 64'd5);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("st_flush_keep", 64'(stall_cycles), 64'd5);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_rst_clear", 64'(stall_cycles), 64'd0);
`endif

        // Randomized traffic, checked by the per-cycle comparator
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
